rs_alu: RTL and testbench

- ALU reservation station of the Tomasulo core; sits directly upstream of the combinational ALU.
- Accepts decoded ALU/branch ops from the dispatcher and buffers them until both operands are known.
- Snoops the two CDBs (ALU result bus, load/store result bus) to capture pending operands.
- Each cycle, issues at most one ready op to the ALU through registered outputs: rs_ok, opt, rs1, rs2, imm, en.

---
 rtl/rs_alu.sv | 160 ++++++++++++++++
 tb/tb_rs_alu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu.sv
// ALU reservation station: buffers dispatched ALU/branch ops until both operands are
// known, snoops both CDBs for pending operands, and issues one ready op per cycle.
module rs_alu #(
    parameter int RS_SIZE = 16,
    parameter int RS_W    = 4,
    parameter int ROB_W   = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear,
    input  logic             issue_valid,
    input  logic [5:0]       issue_opt,
    input  logic [31:0]      issue_vj,
    input  logic             issue_qj_rdy,
    input  logic [ROB_W-1:0] issue_qj,
    input  logic [31:0]      issue_vk,
    input  logic             issue_qk_rdy,
    input  logic [ROB_W-1:0] issue_qk,
    input  logic [31:0]      issue_imm,
    input  logic [ROB_W-1:0] issue_dest,
    output logic             full,
    input  logic             cdb1_ok,
    input  logic [ROB_W-1:0] cdb1_en,
    input  logic [31:0]      cdb1_val,
    input  logic             cdb2_ok,
    input  logic [ROB_W-1:0] cdb2_en,
    input  logic [31:0]      cdb2_val,
    output logic             rs_ok,
    output logic [5:0]       opt,
    output logic [31:0]      rs1,
    output logic [31:0]      rs2,
    output logic [31:0]      imm,
    output logic [ROB_W-1:0] en
);

    typedef struct packed {
        logic             busy;
        logic [5:0]       opt;
        logic [31:0]      vj;
        logic             qj_rdy;
        logic [ROB_W-1:0] qj;
        logic [31:0]      vk;
        logic             qk_rdy;
        logic [ROB_W-1:0] qk;
        logic [31:0]      imm;
        logic [ROB_W-1:0] dest;
    } entry_t;

    typedef struct packed {
        logic             ok;
        logic [ROB_W-1:0] en;
        logic [31:0]      val;
    } cdb_t;

    typedef struct packed {
        logic        rdy;
        logic [31:0] val;
    } opnd_t;

    entry_t             ent [RS_SIZE];
    entry_t             ins_ent;
    cdb_t               cdb1;
    cdb_t               cdb2;
    opnd_t              ins_j;
    opnd_t              ins_k;
    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_W-1:0]    free_idx;
    logic [RS_W-1:0]    sel_idx;
    logic               sel_found;

    assign cdb1 = '{ok: cdb1_ok, en: cdb1_en, val: cdb1_val};
    assign cdb2 = '{ok: cdb2_ok, en: cdb2_en, val: cdb2_val};

    // A pending operand captures from cdb1 first, then cdb2; ready operands keep their value.
    function automatic opnd_t snoop(input logic rdy, input logic [ROB_W-1:0] tag,
                                    input logic [31:0] val, input cdb_t a, input cdb_t b);
        if (rdy)                   return '{rdy: 1'b1, val: val};
        if (a.ok && a.en == tag)   return '{rdy: 1'b1, val: a.val};
        if (b.ok && b.en == tag)   return '{rdy: 1'b1, val: b.val};
        return '{rdy: 1'b0, val: val};
    endfunction

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].busy & ent[i].qj_rdy & ent[i].qk_rdy;
        end
    end

    assign full      = &busy_vec;
    assign sel_found = |ready_vec;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        // Scanning downwards lets the lowest matching index win.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_vec[i]) free_idx = RS_W'(i);
            if (ready_vec[i]) sel_idx  = RS_W'(i);
        end
    end

    always_comb begin
        ins_j   = snoop(issue_qj_rdy, issue_qj, issue_vj, cdb1, cdb2);
        ins_k   = snoop(issue_qk_rdy, issue_qk, issue_vk, cdb1, cdb2);
        ins_ent = '{busy:   1'b1,
                    opt:    issue_opt,
                    vj:     ins_j.val,
                    qj_rdy: ins_j.rdy,
                    qj:     issue_qj,
                    vk:     ins_k.val,
                    qk_rdy: ins_k.rdy,
                    qk:     issue_qk,
                    imm:    issue_imm,
                    dest:   issue_dest};
    end

    // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: only the busy bits need reset; payload fields are never read while an entry is free.
            for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
            rs_ok <= 1'b0;
            opt   <= '0;
            rs1   <= '0;
            rs2   <= '0;
            imm   <= '0;
            en    <= '0;
        end else if (!rdy_in) begin
            rs_ok <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
            rs_ok <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent[i].busy) begin
                    {ent[i].qj_rdy, ent[i].vj} <= snoop(ent[i].qj_rdy, ent[i].qj, ent[i].vj, cdb1, cdb2);
                    {ent[i].qk_rdy, ent[i].vk} <= snoop(ent[i].qk_rdy, ent[i].qk, ent[i].vk, cdb1, cdb2);
                end
            end

            rs_ok <= sel_found;
            if (sel_found) begin
                opt                <= ent[sel_idx].opt;
                rs1                <= ent[sel_idx].vj;
                rs2                <= ent[sel_idx].vk;
                imm                <= ent[sel_idx].imm;
                en                 <= ent[sel_idx].dest;
                ent[sel_idx].busy  <= 1'b0;
            end

            // The free slot comes from pre-edge state, so it never collides with the issuing entry.
            if (issue_valid && !full) ent[free_idx] <= ins_ent;
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu: directed ops push their expected ALU issue (values and
// issue cycle) into a queue; a negedge monitor pops and compares on every rs_ok.
module tb_rs_alu;

    localparam int ROB_W = 4;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_ADDI = 6'd2;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_XOR  = 6'd4;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             clear;
    logic             issue_valid;
    logic [5:0]       issue_opt;
    logic [31:0]      issue_vj;
    logic             issue_qj_rdy;
    logic [ROB_W-1:0] issue_qj;
    logic [31:0]      issue_vk;
    logic             issue_qk_rdy;
    logic [ROB_W-1:0] issue_qk;
    logic [31:0]      issue_imm;
    logic [ROB_W-1:0] issue_dest;
    logic             full;
    logic             cdb1_ok;
    logic [ROB_W-1:0] cdb1_en;
    logic [31:0]      cdb1_val;
    logic             cdb2_ok;
    logic [ROB_W-1:0] cdb2_en;
    logic [31:0]      cdb2_val;
    logic             rs_ok;
    logic [5:0]       opt;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [31:0]      imm;
    logic [ROB_W-1:0] en;

    typedef struct packed {
        logic [5:0]       opt;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [31:0]      imm;
        logic [ROB_W-1:0] en;
        logic [31:0]      at;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] cyc = '0;
    int          n_vec  = 0;
    int          n_miss = 0;

    rs_alu dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .issue_valid(issue_valid), .issue_opt(issue_opt),
        .issue_vj(issue_vj), .issue_qj_rdy(issue_qj_rdy), .issue_qj(issue_qj),
        .issue_vk(issue_vk), .issue_qk_rdy(issue_qk_rdy), .issue_qk(issue_qk),
        .issue_imm(issue_imm), .issue_dest(issue_dest), .full(full),
        .cdb1_ok(cdb1_ok), .cdb1_en(cdb1_en), .cdb1_val(cdb1_val),
        .cdb2_ok(cdb2_ok), .cdb2_en(cdb2_en), .cdb2_val(cdb2_val),
        .rs_ok(rs_ok), .opt(opt), .rs1(rs1), .rs2(rs2), .imm(imm), .en(en)
    );

    always #5 clk_in = ~clk_in;

    // cyc equals the index of the most recent rising edge.
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] i, input logic [ROB_W-1:0] d, input logic [31:0] at);
        sb.push_back('{opt: o, rs1: a, rs2: b, imm: i, en: d, at: at});
    endtask

    // Presents one op for exactly one rising edge.
    task automatic issue(input logic [5:0] o, input logic [31:0] vj, input logic jr,
                         input logic [ROB_W-1:0] qj, input logic [31:0] vk, input logic kr,
                         input logic [ROB_W-1:0] qk, input logic [31:0] im,
                         input logic [ROB_W-1:0] d);
        issue_valid  = 1'b1;
        issue_opt    = o;
        issue_vj     = vj;
        issue_qj_rdy = jr;
        issue_qj     = qj;
        issue_vk     = vk;
        issue_qk_rdy = kr;
        issue_qk     = qk;
        issue_imm    = im;
        issue_dest   = d;
        tick();
        issue_valid  = 1'b0;
    endtask

    // Monitor: every rs_ok must match the oldest expected issue, including its cycle.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk_in);
            if (rst_in === 1'b0 && rs_ok === 1'b1) begin
                got = '{opt: opt, rs1: rs1, rs2: rs2, imm: imm, en: en, at: cyc};
                n_vec++;
                if (sb.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_issue: cycle %0d opt=%0d rs1=0x%0h rs2=0x%0h imm=0x%0h en=%0d, required no issue",
                             cyc, opt, rs1, rs2, imm, en);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_miss++;
                        $display("FAIL issue_compare: got cyc=%0d opt=%0d rs1=0x%0h rs2=0x%0h imm=0x%0h en=%0d, required cyc=%0d opt=%0d rs1=0x%0h rs2=0x%0h imm=0x%0h en=%0d",
                                 got.at, got.opt, got.rs1, got.rs2, got.imm, got.en,
                                 e.at, e.opt, e.rs1, e.rs2, e.imm, e.en);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
        issue_valid = 1'b0; issue_opt = '0; issue_vj = '0; issue_qj_rdy = 1'b0; issue_qj = '0;
        issue_vk = '0; issue_qk_rdy = 1'b0; issue_qk = '0; issue_imm = '0; issue_dest = '0;
        cdb1_ok = 1'b0; cdb1_en = '0; cdb1_val = '0;
        cdb2_ok = 1'b0; cdb2_en = '0; cdb2_val = '0;
        idle(2);
        @(negedge clk_in);
        check("reset_rs_ok", {31'd0, rs_ok}, 32'd0);
        check("reset_full",  {31'd0, full},  32'd0);
        check("reset_opt",   {26'd0, opt},   32'd0);
        check("reset_rs1",   rs1,            32'd0);
        check("reset_rs2",   rs2,            32'd0);
        check("reset_imm",   imm,            32'd0);
        check("reset_en",    {28'd0, en},    32'd0);
        rst_in = 1'b0;
        tick();

        // ADDI, both operands ready: written at edge N, issued at edge N+1.
        push(OP_ADDI, 32'd5, 32'd0, 32'd7, 4'd3, cyc + 2);
        issue(OP_ADDI, 32'd5, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd7, 4'd3);
        idle(3);

        // ADD waiting on tag 2, woken by cdb1 two cycles after insertion.
        issue(OP_ADD, 32'hDEAD, 1'b0, 4'd2, 32'd10, 1'b1, 4'd0, 32'd0, 4'd6);
        tick();
        cdb1_ok = 1'b1; cdb1_en = 4'd2; cdb1_val = 32'h20;
        push(OP_ADD, 32'h20, 32'd10, 32'd0, 4'd6, cyc + 2);
        tick();
        cdb1_ok = 1'b0;
        idle(3);

        // Operand forwarded from cdb2 during the insertion cycle.
        cdb2_ok = 1'b1; cdb2_en = 4'd5; cdb2_val = 32'hFFFF_FFFF;
        push(OP_SUB, 32'h11, 32'hFFFF_FFFF, 32'd0, 4'd1, cyc + 2);
        issue(OP_SUB, 32'h11, 1'b1, 4'd0, 32'd0, 1'b0, 4'd5, 32'd0, 4'd1);
        cdb2_ok = 1'b0;
        idle(3);

        // Fill all 16 entries, entry i waiting on tag i.
        for (int i = 0; i < 16; i++)
            issue(OP_XOR, 32'h100 + i, 1'b0, 4'(i), 32'h200 + i, 1'b1, 4'd0, 32'(i), 4'(i));
        @(negedge clk_in);
        check("full_after_fill", {31'd0, full}, 32'd1);
        $display("note: dispatcher protocol violation driven (issue_valid while full), op must be dropped");
        issue(OP_ADDI, 32'hBAD, 1'b1, 4'd0, 32'hBAD, 1'b1, 4'd0, 32'hBAD, 4'd15);
        @(negedge clk_in);
        check("full_after_drop", {31'd0, full}, 32'd1);

        // Wake entry 3 only; full falls the cycle after it is freed.
        cdb1_ok = 1'b1; cdb1_en = 4'd3; cdb1_val = 32'h333;
        push(OP_XOR, 32'h333, 32'h203, 32'd3, 4'd3, cyc + 2);
        tick();
        cdb1_ok = 1'b0;
        @(negedge clk_in);
        check("full_at_wake", {31'd0, full}, 32'd1);
        tick();
        @(negedge clk_in);
        check("full_after_free", {31'd0, full}, 32'd0);

        // Drain the rest through cdb2, one tag per cycle (includes tag 0).
        for (int t = 0; t < 16; t++) begin
            if (t != 3) begin
                cdb2_ok = 1'b1; cdb2_en = 4'(t); cdb2_val = 32'h400 + t;
                push(OP_XOR, 32'h400 + t, 32'h200 + t, 32'(t), 4'(t), cyc + 2);
                tick();
            end
        end
        cdb2_ok = 1'b0;
        idle(3);

        // Entries 0,1,2 become ready together and issue in index order.
        issue(OP_ADD, 32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd9, 32'd0, 4'd12);
        issue(OP_SUB, 32'd2, 1'b1, 4'd0, 32'd0, 1'b0, 4'd9, 32'd0, 4'd5);
        issue(OP_XOR, 32'd3, 1'b1, 4'd0, 32'd0, 1'b0, 4'd9, 32'd0, 4'd9);
        cdb1_ok = 1'b1; cdb1_en = 4'd9; cdb1_val = 32'h99;
        push(OP_ADD, 32'd1, 32'h99, 32'd0, 4'd12, cyc + 2);
        push(OP_SUB, 32'd2, 32'h99, 32'd0, 4'd5,  cyc + 3);
        push(OP_XOR, 32'd3, 32'h99, 32'd0, 4'd9,  cyc + 4);
        tick();
        cdb1_ok = 1'b0;
        idle(4);

        // Flush with 4 busy entries (one about to issue) and a same-cycle issue.
        for (int i = 0; i < 3; i++)
            issue(OP_ADD, 32'd0, 1'b0, 4'd4, 32'd0, 1'b1, 4'd0, 32'd0, 4'(i + 1));
        issue(OP_SUB, 32'h44, 1'b1, 4'd0, 32'h44, 1'b1, 4'd0, 32'd0, 4'd4);
        clear = 1'b1;
        issue(OP_ADDI, 32'h77, 1'b1, 4'd0, 32'h77, 1'b1, 4'd0, 32'd0, 4'd7);
        clear = 1'b0;
        @(negedge clk_in);
        check("clear_rs_ok", {31'd0, rs_ok}, 32'd0);
        check("clear_full",  {31'd0, full},  32'd0);
        cdb1_ok = 1'b1; cdb1_en = 4'd4; cdb1_val = 32'h4444;
        tick();
        cdb1_ok = 1'b0;
        idle(4);

        // Pause while one op has just issued and another is ready.
        push(OP_ADD, 32'hA, 32'hA0, 32'd0, 4'd10, cyc + 2);
        issue(OP_ADD, 32'hA, 1'b1, 4'd0, 32'hA0, 1'b1, 4'd0, 32'd0, 4'd10);
        issue(OP_SUB, 32'hB, 1'b1, 4'd0, 32'hB0, 1'b1, 4'd0, 32'd0, 4'd11);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk_in);
            check("pause_rs_ok", {31'd0, rs_ok}, 32'd0);
        end
        rdy_in = 1'b1;
        push(OP_SUB, 32'hB, 32'hB0, 32'd0, 4'd11, cyc + 1);
        idle(4);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
